// File: rtl/wb_pipe_reg.sv
// ============================================================================
// Module   : wb_pipe_reg
// Brief    : MEM->WB pipeline register with valid/ready handshake and a
//            saturating backpressure counter. Define WB_PIPE_SKID_EN for a
//            2-entry skid buffer with registered in_ready.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_pipe_reg #(
  parameter int DATA_W = 97,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_regwrite,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_regwrite,
  output logic [RD_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [DATA_W-1:0] r_head_data;
  logic [RD_W-1:0]   r_head_rd;
  logic              r_head_rw;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_retire;
  logic [CNT_W-1:0]  r_stall_cnt;

`ifdef WB_PIPE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_skid_data;
  logic [RD_W-1:0]   r_skid_rd;
  logic              r_skid_rw;
  logic              w_load_head_in;
  logic              w_load_head_skid;
  logic              w_load_skid;

  assign w_out_valid = (r_state != EMPTY);
  assign w_accept    = in_valid && r_in_ready;
  assign w_retire    = w_out_valid && out_ready;
  assign in_ready    = r_in_ready;

  always_comb begin
    w_next_state     = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_next_state = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_next_state   = ONE;
            w_load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_retire) begin
            w_load_head_in = 1'b1;
          end else if (w_accept) begin
            w_next_state = TWO;
            w_load_skid  = 1'b1;
          end else if (w_retire) begin
            w_next_state = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a retire can occur
          if (w_retire) begin
            w_next_state     = ONE;
            w_load_head_skid = 1'b1;
          end
        end
        default: w_next_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != TWO);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_head_data <= '0;
      r_head_rd   <= '0;
      r_head_rw   <= 1'b0;
      r_skid_data <= '0;
      r_skid_rd   <= '0;
      r_skid_rw   <= 1'b0;
    end else begin
      if (w_load_head_in) begin
        r_head_data <= in_data;
        r_head_rd   <= in_rd;
        r_head_rw   <= in_regwrite;
      end else if (w_load_head_skid) begin
        r_head_data <= r_skid_data;
        r_head_rd   <= r_skid_rd;
        r_head_rw   <= r_skid_rw;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_rd   <= in_rd;
        r_skid_rw   <= in_regwrite;
      end
    end
  end

`else

  logic r_valid;

  assign w_out_valid = r_valid;
  assign in_ready    = !r_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_retire    = r_valid && out_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid     <= 1'b0;
      r_head_data <= '0;
      r_head_rd   <= '0;
      r_head_rw   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_head_data <= in_data;
      r_head_rd   <= in_rd;
      r_head_rw   <= in_regwrite;
    end else if (w_retire) begin
      r_valid <= 1'b0;
    end
  end

`endif

  // A flush edge leaves the counter untouched even if the head was stalled
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_cnt <= '0;
    end else if (!flush && w_out_valid && !out_ready && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid    = w_out_valid;
  assign out_data     = r_head_data;
  assign out_rd       = w_out_valid ? r_head_rd : '0;
  assign out_regwrite = w_out_valid && r_head_rw && (r_head_rd != '0);
  assign stall_cnt    = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_pipe_reg.sv
// ============================================================================
// Module   : tb_wb_pipe_reg
// Brief    : Self-checking bench for wb_pipe_reg (CNT_W=4 build); adapts
//            in_ready expectations when WB_PIPE_SKID_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_pipe_reg;

  localparam int DW = 97;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_regwrite = 1'b0;
  logic [RW-1:0] in_rd = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_regwrite;
  logic [RW-1:0] out_rd;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  wb_pipe_reg #(.DATA_W(DW), .RD_W(RW), .CNT_W(CW)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_regwrite (in_regwrite),
    .in_rd       (in_rd),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_regwrite(out_regwrite),
    .out_rd      (out_rd),
    .stall_cnt   (stall_cnt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic          iv;
    logic [DW-1:0] id;
    logic          irw;
    logic [RW-1:0] ird;
    logic          fl;
    logic          ov;
    logic [DW-1:0] od;
    logic          orw;
    logic [RW-1:0] ord;
  } vec_t;

  vec_t          tbl [7];
  logic [DW-1:0] vals [4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_regwrite"}, out_regwrite, 0);
    chk({tag, "_out_rd"}, out_rd, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST_N = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    #1;
    check_zero(tag);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    int sent;
    int got;
    logic acc;

    vals[0] = 97'hA1;
    vals[1] = 97'hB2;
    vals[2] = 97'hC3;
    vals[3] = 97'hD4;
    //            iv  id      irw ird    fl  ov  od      orw ord
    tbl[0] = '{1'b1, 97'h5,  1'b1, 5'd3,  1'b0, 1'b1, 97'h5,  1'b1, 5'd3};
    tbl[1] = '{1'b1, 97'h11, 1'b1, 5'd0,  1'b0, 1'b1, 97'h11, 1'b0, 5'd0};
    tbl[2] = '{1'b1, 97'h22, 1'b0, 5'd7,  1'b0, 1'b1, 97'h22, 1'b0, 5'd7};
    tbl[3] = '{1'b0, 97'h0,  1'b0, 5'd0,  1'b0, 1'b0, 97'h0,  1'b0, 5'd0};
    tbl[4] = '{1'b1, 97'h33, 1'b1, 5'd31, 1'b0, 1'b1, 97'h33, 1'b1, 5'd31};
    tbl[5] = '{1'b1, 97'h44, 1'b1, 5'd9,  1'b1, 1'b0, 97'h0,  1'b0, 5'd0};
    tbl[6] = '{1'b1, 97'h55, 1'b1, 5'd2,  1'b0, 1'b1, 97'h55, 1'b1, 5'd2};

    // Reset state and first-edge accept, then the table with out_ready high
    do_reset("rst0");
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      in_valid    = tbl[i].iv;
      in_data     = tbl[i].id;
      in_regwrite = tbl[i].irw;
      in_rd       = tbl[i].ird;
      flush       = tbl[i].fl;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
      if (tbl[i].ov) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
      chk($sformatf("vec%0d_out_regwrite", i), out_regwrite, tbl[i].orw);
      chk($sformatf("vec%0d_out_rd", i), out_rd, tbl[i].ord);
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      chk($sformatf("vec%0d_stall_cnt", i), stall_cnt, 0);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    flush = 1'b0;

    // Four entries under three stalled cycles, drained in order
    do_reset("rst1");
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge CLK);
      in_valid    = (sent < 4);
      in_data     = vals[sent % 4];
      in_rd       = 5'(sent + 1);
      in_regwrite = 1'b1;
      out_ready   = (cyc >= 4);
      #1;
      acc = in_valid && in_ready;
      if (cyc >= 1 && cyc <= 3) begin
        chk($sformatf("stall%0d_out_valid", cyc), out_valid, 1);
        chk($sformatf("stall%0d_frozen_data", cyc), out_data, vals[0]);
`ifndef WB_PIPE_SKID_EN
        chk($sformatf("stall%0d_in_ready", cyc), in_ready, 0);
`endif
      end
      if (cyc == 4) begin
        chk("stall_cnt_after_3", stall_cnt, 3);
`ifdef WB_PIPE_SKID_EN
        chk("skid_full_in_ready", in_ready, 0);
`endif
      end
      if (out_valid && out_ready) begin
        chk($sformatf("order%0d_data", got), out_data, vals[got]);
        got++;
      end
      @(posedge CLK);
      if (acc) sent++;
    end
    chk("drain_count", got, 4);
    #1;
    chk("stall_cnt_after_drain", stall_cnt, 3);
    @(negedge CLK);
    in_valid = 1'b0;

    // Flush with entries held and a valid input on the same edge
    do_reset("rst2");
    in_valid = 1'b1;
    in_data = 97'hA1;
    in_rd = 5'd4;
    in_regwrite = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_data = 97'hB2;
    @(posedge CLK);
    #1;
`ifdef WB_PIPE_SKID_EN
    chk("two_held_in_ready", in_ready, 0);
`endif
    chk("pre_flush_stall_cnt", stall_cnt, 1);
    @(negedge CLK);
    flush = 1'b1;
    in_data = 97'hEE;
    @(posedge CLK);
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_stall_cnt", stall_cnt, 1);
    @(negedge CLK);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    chk("flush_input_dropped", out_valid, 0);
    chk("flush_out_rd", out_rd, 0);

    // Counter saturation at 15 with a 4-bit counter
    do_reset("rst3");
    in_valid = 1'b1;
    in_data = 97'h77;
    in_rd = 5'd0;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (14) @(posedge CLK);
    #1;
    chk("stall_cnt_14", stall_cnt, 14);
    repeat (7) @(posedge CLK);
    #1;
    chk("stall_cnt_sat", stall_cnt, 15);
    chk("sat_out_data", out_data, 97'h77);
    chk("sat_regwrite_rd0", out_regwrite, 0);

    // Asynchronous reset between edges while full
    do_reset("rst4");
    in_valid = 1'b1;
    in_data = 97'h1234;
    in_rd = 5'd6;
    @(posedge CLK);
    @(negedge CLK);
    in_data = 97'h5678;
    @(posedge CLK);
    #1;
    chk("prefill_out_valid", out_valid, 1);
    #1;
    RST_N = 1'b0;
    #1;
    check_zero("async");
    @(negedge CLK);
    RST_N = 1'b1;
    in_valid = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_async_empty", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
